// File: rtl/hdl_1_dataflow.sv
// hdl_1_dataflow: fixed 4-input Boolean function F(W,X,Y,Z) = sum m(0,1,8,9,10,11,12,14,15).
// The module provides three results:
//   - a combinational result f;
//   - a registered, valid-qualified copy (f_q / out_valid);
//   - a saturating count of accepted samples with F=1.
// Optional feature macro: SELF_CHECK_EN. When defined, f is cross-checked
// against a 16-entry truth-table constant on every accepted sample, and any
// disagreement raises the sticky chk_err flag.
module hdl_1_dataflow #(
    parameter int HIT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             w,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    output logic             f,
    output logic             f_q,
    output logic             out_valid,
    output logic [HIT_W-1:0] hit_cnt,
    output logic             chk_err
);

    localparam logic [HIT_W-1:0] CNT_MAX = {HIT_W{1'b1}};

    logic             f_reg_q;
    logic             f_reg_d;
    logic             vld_q;
    logic             vld_d;
    logic [HIT_W-1:0] cnt_q;
    logic [HIT_W-1:0] cnt_d;

    // Minimised sum-of-products form of the minterm list; no clock or reset involvement
    assign f = (~x & ~y) | (w & (~x | y | ~z));

    // Next-state: capture f and bump the saturating hit counter on accepted samples
    always_comb begin
        f_reg_d = f_reg_q;
        cnt_d   = cnt_q;
        vld_d   = in_valid;
        if (in_valid) begin
            f_reg_d = f;
            if (f && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + {{(HIT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // State registers; reset clears everything at once, dropping any in-flight sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_reg_q <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            f_reg_q <= f_reg_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign f_q       = f_reg_q;
    assign out_valid = vld_q;
    assign hit_cnt   = cnt_q;

`ifdef SELF_CHECK_EN
    // Bit i of the constant is F(i), indexed by {w,x,y,z}
    localparam logic [15:0] F_LUT = 16'hDF03;

    logic       err_q;
    logic       err_d;
    logic       lut_bit;
    logic [3:0] lut_idx;

    assign lut_idx = {w, x, y, z};
    assign lut_bit = F_LUT[lut_idx];

    // Sticky flag: any accepted sample where the equation disagrees with the table
    always_comb begin
        err_d = err_q;
        if (in_valid && (lut_bit != f)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register; only reset can clear it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign chk_err = err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_hdl_1_dataflow.sv
// Directed testbench for hdl_1_dataflow (default 8-bit counter plus a 2-bit saturation instance).
module tb_hdl_1_dataflow;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       w, x, y, z;
    logic       f, f_q, out_valid, chk_err;
    logic [7:0] hit_cnt;

    logic       s_valid;
    logic       s_w, s_x, s_y, s_z;
    logic       s_f, s_f_q, s_out_valid, s_chk_err;
    logic [1:0] s_hit_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Hand-written truth table: bit i = F(i)
    logic [15:0] ftab = 16'b1101_1111_0000_0011;

    hdl_1_dataflow #(.HIT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .w(w), .x(x), .y(y), .z(z),
        .f(f), .f_q(f_q), .out_valid(out_valid),
        .hit_cnt(hit_cnt), .chk_err(chk_err)
    );

    hdl_1_dataflow #(.HIT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_valid),
        .w(s_w), .x(s_x), .y(s_y), .z(s_z),
        .f(s_f), .f_q(s_f_q), .out_valid(s_out_valid),
        .hit_cnt(s_hit_cnt), .chk_err(s_chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
        else begin
            pass_cnt++;
            $display("ok   %s: %b", name, act);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else begin
            pass_cnt++;
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] idx);
        in_valid = v;
        {w, x, y, z} = idx;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        drive(1'b1, 4'd0);
        s_valid = 1'b0;
        {s_w, s_x, s_y, s_z} = 4'd0;
        #2 rst_n = 1'b0;
        #1;
        chk1("reset f_q", f_q, 1'b0);
        chk1("reset out_valid", out_valid, 1'b0);
        chk8("reset hit_cnt", hit_cnt, 8'd0);
        chk1("reset chk_err", chk_err, 1'b0);
        chk1("reset f comb idx0", f, 1'b1);
        // Clock edges while held in reset must not load anything
        @(posedge clk);
        @(negedge clk);
        chk1("reset held out_valid", out_valid, 1'b0);
        chk8("reset held hit_cnt", hit_cnt, 8'd0);
        drive(1'b0, 4'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep;
        logic [3:0] idx;
        logic [3:0] prev;
        prev = 4'd0;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk1($sformatf("sweep f_q idx%0d", prev), f_q, ftab[prev]);
                chk1($sformatf("sweep out_valid idx%0d", prev), out_valid, 1'b1);
            end
            if (i == 16) begin
                chk8("sweep hit_cnt after 16", hit_cnt, 8'd9);
                chk1("sweep chk_err", chk_err, 1'b0);
            end
            idx = 4'(i);
            drive(1'b1, idx);
            #1;
            chk1($sformatf("sweep f idx%0d", idx), f, ftab[idx]);
            prev = idx;
        end
    endtask

    task automatic test_hold;
        // Wrap sample (index 0) was accepted on the preceding edge
        @(negedge clk);
        chk1("wrap f_q", f_q, 1'b1);
        chk1("wrap out_valid", out_valid, 1'b1);
        chk8("wrap hit_cnt", hit_cnt, 8'd10);
        drive(1'b0, 4'd13);
        #1;
        chk1("hold f idx13", f, 1'b0);
        @(negedge clk);
        chk1("hold out_valid", out_valid, 1'b0);
        chk1("hold f_q", f_q, 1'b1);
        chk8("hold hit_cnt", hit_cnt, 8'd10);
    endtask

    task automatic test_reset_mid;
        // Restart a sweep from a clean state
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            drive(1'b1, 4'(i));
        end
        @(negedge clk);
        chk8("mid hit_cnt before reset", hit_cnt, 8'd5);
        chk1("mid f_q before reset", f_q, 1'b1);
        chk1("mid out_valid before reset", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("mid reset f_q", f_q, 1'b0);
        chk1("mid reset out_valid", out_valid, 1'b0);
        chk8("mid reset hit_cnt", hit_cnt, 8'd0);
        drive(1'b1, 4'd2);
        #1;
        chk1("mid reset f idx2", f, 1'b0);
        drive(1'b1, 4'd8);
        #1;
        chk1("mid reset f idx8", f, 1'b1);
        @(negedge clk);
        drive(1'b0, 4'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk1("mid released out_valid", out_valid, 1'b0);
        chk8("mid released hit_cnt", hit_cnt, 8'd0);
    endtask

    task automatic test_saturation;
        logic [1:0] exp_sat [5];
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            {s_w, s_x, s_y, s_z} = 4'd0;
            @(negedge clk);
            s_valid = 1'b0;
            chk8($sformatf("sat hit_cnt sample%0d", i), {6'd0, s_hit_cnt}, {6'd0, exp_sat[i]});
        end
        chk1("sat chk_err", s_chk_err, 1'b0);
    endtask

    // Watchdog so the run always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sweep();
        test_hold();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
